ts_header_monitor: RTL and testbench

TS_HEADER_MONITOR -- requirements
Module: ts_header_monitor

---
 rtl/ts_header_monitor.sv | 251 +++++++++++++++++++++++++
 tb/tb_ts_header_monitor.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_header_monitor.sv
`default_nettype none
// ts_header_monitor: MPEG-TS 4-byte header parser with per-PID continuity-counter checking.
// Revision 1.0 - initial release.
module ts_header_monitor #(
  parameter int NUM_PIDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  input  logic        sop,
  output logic        hdr_valid,
  output logic [12:0] pid,
  output logic [3:0]  cc,
  output logic [1:0]  afc,
  output logic        tei,
  output logic        pusi,
  output logic        cc_error,
  output logic        sync_byte_error,
  output logic [15:0] pkt_count,
  output logic [15:0] cc_err_count,
  output logic [15:0] tei_count,
  output logic        table_full
);

  localparam int          IDXW      = (NUM_PIDS > 1) ? $clog2(NUM_PIDS) : 1;
  localparam logic [7:0]  SYNC_BYTE = 8'h47;
  localparam logic [12:0] NULL_PID  = 13'h1FFF;
  localparam logic [7:0]  LAST_BYTE = 8'd187;
  localparam logic [7:0]  FIRST_PAY = 8'd4;
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR1    = 3'd1;
  localparam logic [2:0] ST_HDR2    = 3'd2;
  localparam logic [2:0] ST_HDR3    = 3'd3;
  localparam logic [2:0] ST_PAYLOAD = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [7:0]  r_byte_cnt;

  logic        w_sync_err;
  logic        w_cap1;
  logic        w_cap2;
  logic        w_hdr_done;
  logic        w_pay_adv;

  logic        r_tei_sh;
  logic        r_pusi_sh;
  logic [12:0] r_pid_sh;

  logic              r_tab_valid   [NUM_PIDS];
  logic [12:0]       r_tab_pid     [NUM_PIDS];
  logic [3:0]        r_tab_last_cc [NUM_PIDS];
  logic              r_tab_dup     [NUM_PIDS];

  logic              w_hit;
  logic [IDXW-1:0]   w_hit_idx;
  logic              w_free;
  logic [IDXW-1:0]   w_free_idx;
  logic [3:0]        w_new_cc;
  logic [1:0]        w_new_afc;
  logic [3:0]        w_last_cc;
  logic              w_last_dup;
  logic              w_check;
  logic              w_is_dup;
  logic              w_err;
  logic              w_cc_err;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: a valid sop always restarts header parsing, whatever the state
  always_comb begin
    w_next_state = r_state;
    if (byte_valid) begin
      if (sop) begin
        w_next_state = (byte_in == SYNC_BYTE) ? ST_HDR1 : ST_IDLE;
      end else begin
        case (r_state)
          ST_IDLE:    w_next_state = ST_IDLE;
          ST_HDR1:    w_next_state = ST_HDR2;
          ST_HDR2:    w_next_state = ST_HDR3;
          ST_HDR3:    w_next_state = ST_PAYLOAD;
          ST_PAYLOAD: w_next_state = (r_byte_cnt == LAST_BYTE) ? ST_IDLE : ST_PAYLOAD;
          default:    w_next_state = ST_IDLE;
        endcase
      end
    end
  end

  // Per-byte strobes
  always_comb begin
    w_sync_err = byte_valid && sop && (byte_in != SYNC_BYTE);
    w_cap1     = byte_valid && !sop && (r_state == ST_HDR1);
    w_cap2     = byte_valid && !sop && (r_state == ST_HDR2);
    w_hdr_done = byte_valid && !sop && (r_state == ST_HDR3);
    w_pay_adv  = byte_valid && !sop && (r_state == ST_PAYLOAD);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_byte_cnt <= '0;
    end else if (w_hdr_done) begin
      r_byte_cnt <= FIRST_PAY;
    end else if (w_pay_adv) begin
      r_byte_cnt <= r_byte_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tei_sh  <= 1'b0;
      r_pusi_sh <= 1'b0;
      r_pid_sh  <= '0;
    end else begin
      if (w_cap1) begin
        r_tei_sh       <= byte_in[7];
        r_pusi_sh      <= byte_in[6];
        r_pid_sh[12:8] <= byte_in[4:0];
      end
      if (w_cap2) begin
        r_pid_sh[7:0] <= byte_in;
      end
    end
  end

  assign w_new_cc  = byte_in[3:0];
  assign w_new_afc = byte_in[5:4];

  // Descending scan so the lowest-index free entry wins
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_PIDS - 1; i >= 0; i--) begin
      if (r_tab_valid[i] && (r_tab_pid[i] == r_pid_sh)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDXW'(i);
      end
      if (!r_tab_valid[i]) begin
        w_free     = 1'b1;
        w_free_idx = IDXW'(i);
      end
    end
  end

  assign w_last_cc  = r_tab_last_cc[w_hit_idx];
  assign w_last_dup = r_tab_dup[w_hit_idx];
  assign w_check    = w_hdr_done && !r_tei_sh && (r_pid_sh != NULL_PID);

  // Payload-bearing packets must step cc by one (one repeat allowed); others must repeat it
  always_comb begin
    w_is_dup = 1'b0;
    w_err    = 1'b0;
    if (w_new_afc[0]) begin
      if (w_new_cc != (w_last_cc + 4'd1)) begin
        if ((w_new_cc == w_last_cc) && !w_last_dup) begin
          w_is_dup = 1'b1;
        end else begin
          w_err = 1'b1;
        end
      end
    end else begin
      w_err = (w_new_cc != w_last_cc);
    end
  end

  assign w_cc_err = w_check && w_hit && w_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PIDS; i++) begin
        r_tab_valid[i]   <= 1'b0;
        r_tab_pid[i]     <= '0;
        r_tab_last_cc[i] <= '0;
        r_tab_dup[i]     <= 1'b0;
      end
      table_full <= 1'b0;
    end else if (w_check) begin
      if (w_hit) begin
        r_tab_last_cc[w_hit_idx] <= w_new_cc;
        if (w_new_afc[0]) begin
          r_tab_dup[w_hit_idx] <= w_is_dup;
        end else if (w_err) begin
          r_tab_dup[w_hit_idx] <= 1'b0;
        end
      end else if (w_free) begin
        r_tab_valid[w_free_idx]   <= 1'b1;
        r_tab_pid[w_free_idx]     <= r_pid_sh;
        r_tab_last_cc[w_free_idx] <= w_new_cc;
        r_tab_dup[w_free_idx]     <= 1'b0;
      end else begin
        table_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_valid       <= 1'b0;
      cc_error        <= 1'b0;
      sync_byte_error <= 1'b0;
      pid             <= '0;
      cc              <= '0;
      afc             <= '0;
      tei             <= 1'b0;
      pusi            <= 1'b0;
    end else begin
      hdr_valid       <= w_hdr_done;
      cc_error        <= w_cc_err;
      sync_byte_error <= w_sync_err;
      if (w_hdr_done) begin
        pid  <= r_pid_sh;
        cc   <= w_new_cc;
        afc  <= w_new_afc;
        tei  <= r_tei_sh;
        pusi <= r_pusi_sh;
      end
    end
  end

  // Counters follow the registered pulses and saturate
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_count    <= '0;
      cc_err_count <= '0;
      tei_count    <= '0;
    end else begin
      if (hdr_valid && (pkt_count != CNT_MAX)) begin
        pkt_count <= pkt_count + 16'd1;
      end
      if (hdr_valid && tei && (tei_count != CNT_MAX)) begin
        tei_count <= tei_count + 16'd1;
      end
      if (cc_error && (cc_err_count != CNT_MAX)) begin
        cc_err_count <= cc_err_count + 16'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ts_header_monitor.sv
`default_nettype none
// tb_ts_header_monitor: directed self-checking bench for ts_header_monitor.
// Revision 1.0 - initial release.
module tb_ts_header_monitor;

  logic        clk;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        sop;
  logic        hdr_valid;
  logic [12:0] pid;
  logic [3:0]  cc;
  logic [1:0]  afc;
  logic        tei;
  logic        pusi;
  logic        cc_error;
  logic        sync_byte_error;
  logic [15:0] pkt_count;
  logic [15:0] cc_err_count;
  logic [15:0] tei_count;
  logic        table_full;

  int errors = 0;
  int checks = 0;
  int hv_cnt = 0;
  int ce_cnt = 0;
  int se_cnt = 0;
  logic [12:0] mon_pid = '0;
  logic [3:0]  mon_cc  = '0;

  ts_header_monitor #(.NUM_PIDS(8)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valid(byte_valid), .sop(sop),
    .hdr_valid(hdr_valid), .pid(pid), .cc(cc), .afc(afc), .tei(tei), .pusi(pusi),
    .cc_error(cc_error), .sync_byte_error(sync_byte_error), .pkt_count(pkt_count),
    .cc_err_count(cc_err_count), .tei_count(tei_count), .table_full(table_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (hdr_valid) begin
      hv_cnt++;
      mon_pid = pid;
      mon_cc  = cc;
    end
    if (cc_error) ce_cnt++;
    if (sync_byte_error) se_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic s);
    @(negedge clk);
    byte_in = b; sop = s; byte_valid = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      byte_valid = 1'b0; sop = 1'b0; byte_in = 8'h00;
    end
  endtask

  // Sends the first len bytes of a packet; gap inserts an invalid cycle (with sop high) after byte 1
  task automatic send_pkt(input logic [12:0] p, input logic [3:0] c, input logic [1:0] a,
                          input logic t, input int len, input bit gap);
    for (int i = 0; i < len; i++) begin
      case (i)
        0: send_byte(8'h47, 1'b1);
        1: send_byte({t, 1'b1, 1'b0, p[12:8]}, 1'b0);
        2: send_byte(p[7:0], 1'b0);
        3: send_byte({2'b00, a, c}, 1'b0);
        default: send_byte(8'(i * 7), 1'b0);
      endcase
      if (gap && i == 1) begin
        @(negedge clk);
        byte_valid = 1'b0; sop = 1'b1; byte_in = 8'h47;
      end
    end
  endtask

  task automatic clear_mon();
    hv_cnt = 0; ce_cnt = 0; se_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; byte_valid = 1'b0; sop = 1'b0; byte_in = 8'h00;
    idle(3);
    rst = 1'b1;
    idle(2);
    clear_mon();
  endtask

  task automatic test_reset();
    rst = 1'b0; byte_valid = 1'b0; sop = 1'b0; byte_in = 8'h00;
    idle(3);
    checks++; if ({hdr_valid, cc_error, sync_byte_error, table_full} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 0000", {hdr_valid, cc_error, sync_byte_error, table_full}); end
    checks++; if ({pid, cc, afc, tei, pusi} !== 21'd0) begin errors++; $display("FAIL reset_fields: got %h expected 0", {pid, cc, afc, tei, pusi}); end
    checks++; if ({pkt_count, cc_err_count, tei_count} !== 48'd0) begin errors++; $display("FAIL reset_counters: got %h expected 0", {pkt_count, cc_err_count, tei_count}); end
    rst = 1'b1;
    idle(2);
    clear_mon();
  endtask

  task automatic test_continuity();
    do_reset();
    send_pkt(13'h100, 4'd0, 2'b01, 1'b0, 188, 1'b1);
    idle(2);
    checks++; if (hv_cnt !== 1) begin errors++; $display("FAIL cont_gap_hv: got %0d expected 1", hv_cnt); end
    checks++; if (pusi !== 1'b1) begin errors++; $display("FAIL cont_pusi: got %b expected 1", pusi); end
    for (int k = 1; k < 4; k++) send_pkt(13'h100, 4'(k), 2'b01, 1'b0, 188, 1'b0);
    idle(3);
    checks++; if (hv_cnt !== 4) begin errors++; $display("FAIL cont_hv_count: got %0d expected 4", hv_cnt); end
    checks++; if (mon_pid !== 13'h100) begin errors++; $display("FAIL cont_pid: got %h expected 100", mon_pid); end
    checks++; if (mon_cc !== 4'd3) begin errors++; $display("FAIL cont_cc: got %0d expected 3", mon_cc); end
    checks++; if (afc !== 2'b01) begin errors++; $display("FAIL cont_afc: got %b expected 01", afc); end
    checks++; if (cc_err_count !== 16'd0) begin errors++; $display("FAIL cont_cc_err_count: got %0d expected 0", cc_err_count); end
    checks++; if (pkt_count !== 16'd4) begin errors++; $display("FAIL cont_pkt_count: got %0d expected 4", pkt_count); end
  endtask

  task automatic test_duplicate();
    do_reset();
    send_pkt(13'h100, 4'd5, 2'b01, 1'b0, 188, 1'b0);
    send_pkt(13'h100, 4'd5, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (ce_cnt !== 0) begin errors++; $display("FAIL dup_first: got %0d errors expected 0", ce_cnt); end
    send_pkt(13'h100, 4'd5, 2'b01, 1'b0, 188, 1'b0);
    idle(3);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL dup_second: got %0d errors expected 1", ce_cnt); end
    checks++; if (cc_err_count !== 16'd1) begin errors++; $display("FAIL dup_cc_err_count: got %0d expected 1", cc_err_count); end
  endtask

  task automatic test_jump();
    clear_mon();
    send_pkt(13'h200, 4'd3, 2'b01, 1'b0, 188, 1'b0);
    send_pkt(13'h200, 4'd7, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL jump_err: got %0d expected 1", ce_cnt); end
    send_pkt(13'h200, 4'd8, 2'b01, 1'b0, 188, 1'b0);
    idle(3);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL jump_resync: got %0d expected 1", ce_cnt); end
    checks++; if (cc_err_count !== 16'd2) begin errors++; $display("FAIL jump_cc_err_count: got %0d expected 2", cc_err_count); end
  endtask

  task automatic test_no_payload();
    clear_mon();
    send_pkt(13'h300, 4'd4, 2'b10, 1'b0, 188, 1'b0);
    send_pkt(13'h300, 4'd4, 2'b10, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (ce_cnt !== 0) begin errors++; $display("FAIL nopay_same: got %0d expected 0", ce_cnt); end
    send_pkt(13'h300, 4'd5, 2'b00, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL nopay_reserved_diff: got %0d expected 1", ce_cnt); end
    send_pkt(13'h300, 4'd5, 2'b10, 1'b0, 188, 1'b0);
    send_pkt(13'h300, 4'd6, 2'b01, 1'b0, 188, 1'b0);
    idle(3);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL nopay_follow: got %0d expected 1", ce_cnt); end
    checks++; if (pkt_count !== 16'd11) begin errors++; $display("FAIL nopay_pkt_count: got %0d expected 11", pkt_count); end
    checks++; if (cc_err_count !== 16'd3) begin errors++; $display("FAIL nopay_cc_err_count: got %0d expected 3", cc_err_count); end
  endtask

  task automatic test_table_full();
    do_reset();
    send_pkt(13'h1FFF, 4'd0, 2'b01, 1'b0, 188, 1'b0);
    send_pkt(13'h1FFF, 4'd7, 2'b01, 1'b0, 188, 1'b0);
    send_pkt(13'h050, 4'd0, 2'b01, 1'b1, 188, 1'b0);
    send_pkt(13'h050, 4'd9, 2'b01, 1'b1, 188, 1'b0);
    for (int k = 0; k < 8; k++) send_pkt(13'h010 + 13'(k), 4'd0, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (table_full !== 1'b0) begin errors++; $display("FAIL full_after8: got %b expected 0", table_full); end
    send_pkt(13'h018, 4'd0, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (table_full !== 1'b1) begin errors++; $display("FAIL full_after9: got %b expected 1", table_full); end
    checks++; if (ce_cnt !== 0) begin errors++; $display("FAIL full_no_err: got %0d expected 0", ce_cnt); end
    send_pkt(13'h018, 4'd5, 2'b01, 1'b0, 188, 1'b0);
    send_pkt(13'h010, 4'd2, 2'b01, 1'b0, 188, 1'b0);
    idle(3);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL full_tracked_err: got %0d expected 1", ce_cnt); end
    checks++; if (tei_count !== 16'd2) begin errors++; $display("FAIL full_tei_count: got %0d expected 2", tei_count); end
    checks++; if (pkt_count !== 16'd15) begin errors++; $display("FAIL full_pkt_count: got %0d expected 15", pkt_count); end
  endtask

  task automatic test_sync_abort();
    clear_mon();
    send_byte(8'h46, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    idle(3);
    checks++; if (se_cnt !== 1) begin errors++; $display("FAIL sync_err_pulse: got %0d expected 1", se_cnt); end
    checks++; if (hv_cnt !== 0) begin errors++; $display("FAIL sync_no_hdr: got %0d expected 0", hv_cnt); end
    send_pkt(13'h400, 4'd1, 2'b01, 1'b0, 3, 1'b0);
    send_pkt(13'h401, 4'd2, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (hv_cnt !== 1) begin errors++; $display("FAIL abort_hdr_hv: got %0d expected 1", hv_cnt); end
    checks++; if (mon_pid !== 13'h401) begin errors++; $display("FAIL abort_hdr_pid: got %h expected 401", mon_pid); end
    send_pkt(13'h402, 4'd3, 2'b01, 1'b0, 50, 1'b0);
    send_pkt(13'h403, 4'd4, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (hv_cnt !== 3) begin errors++; $display("FAIL abort_pay_hv: got %0d expected 3", hv_cnt); end
    checks++; if (mon_pid !== 13'h403 || mon_cc !== 4'd4) begin errors++; $display("FAIL abort_pay_hdr: got pid %h cc %0d expected pid 403 cc 4", mon_pid, mon_cc); end
  endtask

  task automatic test_reset_mid();
    send_pkt(13'h100, 4'd1, 2'b01, 1'b0, 101, 1'b0);
    #2 rst = 1'b0;
    #1;
    checks++; if ({pkt_count, cc_err_count, tei_count} !== 48'd0) begin errors++; $display("FAIL rstmid_counters: got %h expected 0", {pkt_count, cc_err_count, tei_count}); end
    checks++; if (table_full !== 1'b0) begin errors++; $display("FAIL rstmid_table_full: got %b expected 0", table_full); end
    idle(2);
    rst = 1'b1;
    idle(1);
    clear_mon();
    for (int k = 0; k < 5; k++) send_byte(8'h47, 1'b0);
    idle(2);
    checks++; if (hv_cnt !== 0) begin errors++; $display("FAIL rstmid_stale: got %0d expected 0", hv_cnt); end
    send_pkt(13'h100, 4'd9, 2'b01, 1'b0, 188, 1'b0);
    send_pkt(13'h100, 4'd10, 2'b01, 1'b0, 188, 1'b0);
    idle(2);
    checks++; if (ce_cnt !== 0) begin errors++; $display("FAIL rstmid_learn: got %0d expected 0", ce_cnt); end
    send_pkt(13'h100, 4'd12, 2'b01, 1'b0, 188, 1'b0);
    idle(3);
    checks++; if (ce_cnt !== 1) begin errors++; $display("FAIL rstmid_tracked: got %0d expected 1", ce_cnt); end
    checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL rstmid_pkt_count: got %0d expected 3", pkt_count); end
  endtask

  initial begin
    rst = 1'b0; byte_in = 8'h00; byte_valid = 1'b0; sop = 1'b0;
    test_reset();
    test_continuity();
    test_duplicate();
    test_jump();
    test_no_payload();
    test_table_full();
    test_sync_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
